alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the execute-stage combinational ALU. Sits in the execute stage of the four-stage controller.
- Keeps the existing 5-bit opcode map and adds:
  - a valid/ready handshake with back-pressure;
  - an architectural carry flag that feeds ADC/SBB;
  - variable-amount shifts and rotates;
  - zero/negative/overflow flags and an illegal-opcode indication.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_pipe_core.sv | 98 +++++++++
 rtl/alu_pipe.sv | 112 +++++++++++
 tb/tb_alu_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined execute-stage ALU.
//   - OP_* : 5-bit opcode map
//   - FLAG_* : bit positions of the registered flag vector
//   - op_updates_cf : which opcodes write the architectural carry flag
package alu_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_INC   = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_ADC   = 5'b00011;
    localparam logic [4:0] OP_SBB   = 5'b00100;
    localparam logic [4:0] OP_SUB   = 5'b00101;
    localparam logic [4:0] OP_DEC   = 5'b00110;
    localparam logic [4:0] OP_MOV   = 5'b00111;
    localparam logic [4:0] OP_ROR   = 5'b01000;
    localparam logic [4:0] OP_SHR   = 5'b01001;
    localparam logic [4:0] OP_SHL   = 5'b01010;
    localparam logic [4:0] OP_ROL   = 5'b01011;
    localparam logic [4:0] OP_OR    = 5'b11000;
    localparam logic [4:0] OP_XOR   = 5'b11010;
    localparam logic [4:0] OP_AND   = 5'b11100;
    localparam logic [4:0] OP_NOT   = 5'b11110;
    localparam logic [4:0] OP_STORE = 5'b11011;

    localparam int unsigned FLAG_CARRY   = 0;
    localparam int unsigned FLAG_ZERO    = 1;
    localparam int unsigned FLAG_NEG     = 2;
    localparam int unsigned FLAG_OVF     = 3;
    localparam int unsigned FLAG_ILLEGAL = 4;
    localparam int unsigned FLAG_W       = 5;

    // Arithmetic ops and the two true shifts write cf; rotates, logic,
    // moves and illegal opcodes leave it untouched.
    function automatic logic op_updates_cf(input logic [4:0] op);
        logic upd;
        upd = 1'b0;
        case (op)
            OP_INC, OP_ADD, OP_ADC, OP_SBB, OP_SUB, OP_DEC,
            OP_SHR, OP_SHL: upd = 1'b1;
            default:        upd = 1'b0;
        endcase
        return upd;
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: purely combinational ALU datapath.
//   a, b      : operands (b[SHAMT_W-1:0] is the shift amount)
//   opcode    : operation select (see alu_pkg)
//   cf_in     : architectural carry flag consumed by ADC/SBB
//   result    : operation result (0 for illegal opcodes)
//   carry     : carry/borrow or last bit shifted out
//   ovf       : signed overflow of the arithmetic ops
//   illegal   : opcode not in the map
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       opcode,
    input  logic             cf_in,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0]   s;
    logic [WIDTH-1:0]     addend;
    logic                 cin;
    logic                 inv_carry;
    logic [WIDTH:0]       sum;
    logic                 add_ovf;
    logic [2*WIDTH-1:0]   shl_ext;
    logic [2*WIDTH-1:0]   shr_ext;
    logic [2*WIDTH-1:0]   ror_ext;
    logic [2*WIDTH-1:0]   rol_ext;

    assign s = b[SHAMT_W-1:0];

    // All arithmetic shares one adder. Subtraction is a + ~x + !borrow_in,
    // so the adder carry-out is the inverse of the borrow.
    always_comb begin
        addend    = b;
        cin       = 1'b0;
        inv_carry = 1'b0;
        case (opcode)
            OP_INC: begin addend = '0; cin = 1'b1; end
            OP_ADD: begin addend = b;  cin = 1'b0; end
            OP_ADC: begin addend = b;  cin = cf_in; end
            OP_SUB: begin addend = ~b; cin = 1'b1;   inv_carry = 1'b1; end
            OP_SBB: begin addend = ~b; cin = ~cf_in; inv_carry = 1'b1; end
            OP_DEC: begin addend = '1; cin = 1'b0;   inv_carry = 1'b1; end
            default: begin addend = b; cin = 1'b0; inv_carry = 1'b0; end
        endcase
    end

    assign sum     = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
    assign add_ovf = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    // Double-width shifts: the bit adjacent to the result half is the last
    // bit shifted out (and is 0 when s == 0).
    assign shl_ext = {{WIDTH{1'b0}}, a} << s;
    assign shr_ext = {a, {WIDTH{1'b0}}} >> s;
    assign ror_ext = {a, a} >> s;
    assign rol_ext = {a, a} << s;

    always_comb begin
        result  = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_NOP:   result = '0;
            OP_INC, OP_ADD, OP_ADC, OP_SBB, OP_SUB, OP_DEC: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH] ^ inv_carry;
                ovf    = add_ovf;
            end
            OP_MOV:   result = a;
            OP_STORE: result = a;
            OP_ROR:   result = ror_ext[WIDTH-1:0];
            OP_ROL:   result = rol_ext[2*WIDTH-1:WIDTH];
            OP_SHR: begin
                result = shr_ext[2*WIDTH-1:WIDTH];
                carry  = shr_ext[WIDTH-1];
            end
            OP_SHL: begin
                result = shl_ext[WIDTH-1:0];
                carry  = shl_ext[WIDTH];
            end
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_AND:   result = a & b;
            OP_NOT:   result = ~a;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined execute-stage ALU with valid/ready flow
// control and an architectural carry flag.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : operand handshake (a_in, b_in, opcode_in)
//   flag_clr           : clear cf (wins over a same-cycle update)
//   out_valid/out_ready: result handshake
//   result, carry, zero, neg, ovf, illegal : registered result and flags
//   cf                 : architectural carry flag register
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [4:0]       opcode_in,
    input  logic             flag_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             illegal,
    output logic             cf
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [4:0]       s1_op;
    logic             s2_adv;
    logic             cf_q;
    logic [FLAG_W-1:0] flags_q;

    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_ovf;
    logic             core_illegal;

    alu_pipe_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a       (s1_a),
        .b       (s1_b),
        .opcode  (s1_op),
        .cf_in   (cf_q),
        .result  (core_result),
        .carry   (core_carry),
        .ovf     (core_ovf),
        .illegal (core_illegal)
    );

    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !rst && (!s1_valid || s2_adv);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            flags_q   <= '0;
            cf_q      <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid <= 1'b1;
                s1_a     <= a_in;
                s1_b     <= b_in;
                s1_op    <= opcode_in;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                out_valid              <= 1'b1;
                result                 <= core_result;
                flags_q[FLAG_CARRY]    <= core_carry;
                // Illegal ops force result 0 but must not report zero.
                flags_q[FLAG_ZERO]     <= !core_illegal && (core_result == '0);
                flags_q[FLAG_NEG]      <= core_result[WIDTH-1];
                flags_q[FLAG_OVF]      <= core_ovf;
                flags_q[FLAG_ILLEGAL]  <= core_illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // cf is read by the core and written on the same edge, so a
            // back-to-back ADC always sees its predecessor's carry.
            if (flag_clr) begin
                cf_q <= 1'b0;
            end else if (s2_adv && op_updates_cf(s1_op)) begin
                cf_q <= core_carry;
            end
        end
    end

    assign carry   = flags_q[FLAG_CARRY];
    assign zero    = flags_q[FLAG_ZERO];
    assign neg     = flags_q[FLAG_NEG];
    assign ovf     = flags_q[FLAG_OVF];
    assign illegal = flags_q[FLAG_ILLEGAL];
    assign cf      = cf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH=32. Expected results
// come from an independent 64-bit / bit-loop reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [4:0]  opcode_in = '0;
    logic        flag_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        carry, zero, neg, ovf, illegal, cf;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        n;
        logic        o;
        logic        ill;
        logic        cf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic model_cf = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic rnd_done = 1'b0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .opcode_in (opcode_in),
        .flag_clr  (flag_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .illegal   (illegal),
        .cf        (cf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic cfi);
        exp_t        e;
        longint unsigned ua, ub, t;
        longint      sa, sbv, st;
        int unsigned s;
        logic [31:0] r;
        logic        c, o, ill, upd, arith;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        s = {27'd0, b[4:0]};
        r = '0; c = 1'b0; o = 1'b0; ill = 1'b0; upd = 1'b0; arith = 1'b0;
        t = '0; st = '0;
        case (op)
            OP_NOP:   r = '0;
            OP_INC:   begin t = ua + 64'd1;  st = sa + 64'sd1; arith = 1'b1; end
            OP_ADD:   begin t = ua + ub;     st = sa + sbv;     arith = 1'b1; end
            OP_ADC:   begin t = ua + ub + 64'(cfi); st = sa + sbv + longint'(64'(cfi)); arith = 1'b1; end
            OP_SBB:   begin t = ua - ub - 64'(cfi); st = sa - sbv - longint'(64'(cfi)); arith = 1'b1; end
            OP_SUB:   begin t = ua - ub;     st = sa - sbv;     arith = 1'b1; end
            OP_DEC:   begin t = ua - 64'd1;  st = sa - 64'sd1;  arith = 1'b1; end
            OP_MOV, OP_STORE: r = a;
            OP_SHL: begin
                r = a; upd = 1'b1;
                for (int unsigned i = 0; i < s; i++) begin c = r[31]; r = {r[30:0], 1'b0}; end
            end
            OP_SHR: begin
                r = a; upd = 1'b1;
                for (int unsigned i = 0; i < s; i++) begin c = r[0]; r = {1'b0, r[31:1]}; end
            end
            OP_ROR: begin
                r = a;
                for (int unsigned i = 0; i < s; i++) r = {r[0], r[31:1]};
            end
            OP_ROL: begin
                r = a;
                for (int unsigned i = 0; i < s; i++) r = {r[30:0], r[31]};
            end
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_AND: r = a & b;
            OP_NOT: r = ~a;
            default: ill = 1'b1;
        endcase
        if (arith) begin
            r = t[31:0];
            c = t[32];
            o = (st[63:31] != '0) && (st[63:31] != '1);
            upd = 1'b1;
        end
        e.res = r;
        e.c   = c;
        e.z   = !ill && (r == '0);
        e.n   = r[31];
        e.o   = o;
        e.ill = ill;
        e.cf  = upd ? c : cfi;
        return e;
    endfunction

    // Scoreboard consumer: an output transfers at the next rising edge
    // whenever out_valid && out_ready is seen here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("result",  result,        mon_e.res);
                check("carry",   32'(carry),    32'(mon_e.c));
                check("zero",    32'(zero),     32'(mon_e.z));
                check("neg",     32'(neg),      32'(mon_e.n));
                check("ovf",     32'(ovf),      32'(mon_e.o));
                check("illegal", 32'(illegal),  32'(mon_e.ill));
                check("cf",      32'(cf),       32'(mon_e.cf));
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic clr);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        opcode_in = op;
        a_in      = a;
        b_in      = b;
        flag_clr  = clr;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            if (clr) begin
                model_cf = 1'b0;
                if (sb.size() != 0) sb[sb.size()-1].cf = 1'b0;
            end
            e = model(op, a, b, model_cf);
            model_cf = e.cf;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flag_clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    logic [4:0]  d_op [17];
    logic [31:0] d_a  [17];
    logic [31:0] d_b  [17];
    logic [4:0]  legal_ops [17];

    initial begin
        d_op = '{OP_SUB, OP_SUB, OP_SHL, OP_ROR, OP_SHR, OP_SBB, OP_INC, OP_DEC, OP_ADC,
                 OP_ROL, OP_MOV, OP_NOT, OP_XOR, OP_AND, OP_OR, OP_STORE, OP_NOP};
        d_a  = '{32'h80000000, 32'h00000001, 32'h80000001, 32'h00000001, 32'h12345678,
                 32'h00000005, 32'h7FFFFFFF, 32'h00000000, 32'h00000001, 32'h80000001,
                 32'hDEADBEEF, 32'h00000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0000000F,
                 32'hCAFEF00D, 32'h12345678};
        d_b  = '{32'h00000001, 32'h00000002, 32'h00000001, 32'h00000004, 32'hFFFFFFE0,
                 32'h00000003, 32'h00000000, 32'h00000000, 32'h00000001, 32'h00000003,
                 32'h00000000, 32'h00000000, 32'h0FF00FF0, 32'h0F0F0F0F, 32'hF0000000,
                 32'h00000000, 32'h11111111};
        legal_ops = '{OP_NOP, OP_INC, OP_ADD, OP_ADC, OP_SBB, OP_SUB, OP_DEC, OP_MOV, OP_ROR,
                      OP_SHR, OP_SHL, OP_ROL, OP_OR, OP_XOR, OP_AND, OP_NOT, OP_STORE};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    result,         32'd0);
        check("rst_flags",     32'({carry, zero, neg, ovf, illegal}), 32'd0);
        check("rst_cf",        32'(cf),        32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1 out_ready = 1'b1;

        // ADD wraparound and two-cycle latency
        issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        @(negedge clk);
        check("latency_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_cycle2", 32'(out_valid), 32'd1);
        drain();

        // Back-to-back ADD -> ADC carry forwarding, then with flag_clr
        issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        issue(OP_ADC, 32'h00000000, 32'h00000000, 1'b0);
        drain();
        issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        issue(OP_ADC, 32'h00000000, 32'h00000000, 1'b1);
        drain();

        // Directed arithmetic, shift, rotate and logic cases
        for (int i = 0; i < 17; i++) issue(d_op[i], d_a[i], d_b[i], 1'b0);
        drain();

        // Illegal opcode leaves cf alone
        issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        issue(5'b01100, 32'h00000005, 32'h00000005, 1'b0);
        drain();
        @(negedge clk);
        check("cf_after_illegal", 32'(cf), 32'd1);

        // Random ops under random back-pressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    issue(legal_ops[$urandom_range(0, 16)], $urandom, $urandom, 1'b0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        // Stall: three ops streamed in while the consumer is blocked
        @(posedge clk); #1 out_ready = 1'b0;
        fork
            begin
                issue(OP_ADD, 32'h00000001, 32'h00000002, 1'b0);
                issue(OP_XOR, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0);
                issue(OP_SHL, 32'h00000003, 32'h00000002, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                check("stall_in_ready",  32'(in_ready),  32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_result_a",  result,         32'd3);
                repeat (2) @(negedge clk);
                check("stall_in_ready2", 32'(in_ready),  32'd0);
                check("stall_result_b",  result,         32'd3);
                check("stall_out_valid2", 32'(out_valid), 32'd1);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full
        @(posedge clk); #1 out_ready = 1'b0;
        issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        issue(OP_ADD, 32'h00000001, 32'h00000001, 1'b0);
        @(negedge clk);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_cf",        32'(cf),        32'd1);
        check("full_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b1;
        #1;
        check("in_ready_in_rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_cf",        32'(cf),        32'd0);
        check("midrst_result",    result,         32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        check("midrst_in_ready2", 32'(in_ready), 32'd0);
        rst = 1'b0;
        sb.delete();
        model_cf = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_pulse_after_rst", 32'(out_valid), 32'd0);
        end
        check("in_ready_recovered", 32'(in_ready), 32'd1);
        issue(OP_ADC, 32'h00000002, 32'h00000003, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
